// File: rtl/icache_2way_pkg.sv
// Shared definitions for the 2-way instruction cache (and any future data cache):
// default geometry, tag width, way-select constants and address split helpers.
package icache_2way_pkg;

    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_ADDR_W     = 32;
    localparam int TAG_W          = DEF_ADDR_W - DEF_INDEX_BITS - 1;

    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

    // Set index: halfword address bits above bit 0 (bit 0 is ignored).
    function automatic logic [DEF_INDEX_BITS-1:0] addr_index(input logic [DEF_ADDR_W-1:0] addr);
        return addr[DEF_INDEX_BITS:1];
    endfunction

    // Tag: every address bit above the index.
    function automatic logic [TAG_W-1:0] addr_tag(input logic [DEF_ADDR_W-1:0] addr);
        return addr[DEF_ADDR_W-1:DEF_INDEX_BITS+1];
    endfunction

endpackage

// File: rtl/icache_2way_way.sv
// One way of the instruction cache: valid/tag/data/is_c per set.
// Two combinational tag compares (lookup port and fill probe port), one synchronous write.
module icache_way #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 25
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  clr,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_match,
    output logic [31:0]           rd_data,
    output logic                  rd_is_c,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data,
    input  logic                  wr_is_c,
    output logic                  wr_match
);
    localparam int SETS = 1 << INDEX_BITS;

    logic [SETS-1:0]     valid;
    logic [SETS-1:0]     is_c_mem;
    logic [TAG_BITS-1:0] tag_mem  [SETS];
    logic [31:0]         data_mem [SETS];

    assign rd_match = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
    assign rd_data  = data_mem[rd_index];
    assign rd_is_c  = is_c_mem[rd_index];
    assign wr_match = valid[wr_index] && (tag_mem[wr_index] == wr_tag);

    // Valid bits: cleared by reset or flush, set by a fill.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_in || clr) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Payload arrays: written on fill only.
    always_ff @(posedge clk_in) begin
        // NOTE: storage arrays carry no reset; the valid bits alone make stale contents invisible.
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
            is_c_mem[wr_index] <= wr_is_c;
        end
    end

endmodule

// File: rtl/icache_2way.sv
// 2-way set-associative instruction cache keyed by halfword address, one LRU bit per set.
// Optional hit/miss performance counters are built when ICACHE_PERF_EN is defined;
// otherwise hit_cnt/miss_cnt are tied to zero.
module icache_2way
    import icache_2way_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush,
    input  logic              icache_get_ready,
    input  logic [ADDR_W-1:0] get_icache_addr,
    output logic              icache_hit,
    output logic [31:0]       icache_data,
    output logic              icache_data_is_c,
    input  logic              wr_ready,
    input  logic              wr_is_c,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_inst,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);
    localparam int TAG_BITS = ADDR_W - INDEX_BITS - 1;
    localparam int SETS     = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0] lk_index, fill_index;
    logic [TAG_BITS-1:0]   lk_tag, fill_tag;
    logic [1:0]            lk_match, fill_match, way_we, rd_is_c;
    logic [31:0]           rd_data0, rd_data1;
    logic [SETS-1:0]       lru;
    logic                  hit_way, fill_way, fill_en, clr_all;
    logic                  unused_bits;

    assign lk_index    = get_icache_addr[INDEX_BITS:1];
    assign lk_tag      = get_icache_addr[ADDR_W-1:INDEX_BITS+1];
    assign fill_index  = wr_addr[INDEX_BITS:1];
    assign fill_tag    = wr_addr[ADDR_W-1:INDEX_BITS+1];
    assign unused_bits = get_icache_addr[0] ^ wr_addr[0];

    icache_way #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_way0 (
        .clk_in(clk_in), .rst_in(rst_in), .clr(clr_all),
        .rd_index(lk_index), .rd_tag(lk_tag), .rd_match(lk_match[0]),
        .rd_data(rd_data0), .rd_is_c(rd_is_c[0]),
        .wr_en(way_we[0]), .wr_index(fill_index), .wr_tag(fill_tag),
        .wr_data(wr_inst), .wr_is_c(wr_is_c), .wr_match(fill_match[0])
    );

    icache_way #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_way1 (
        .clk_in(clk_in), .rst_in(rst_in), .clr(clr_all),
        .rd_index(lk_index), .rd_tag(lk_tag), .rd_match(lk_match[1]),
        .rd_data(rd_data1), .rd_is_c(rd_is_c[1]),
        .wr_en(way_we[1]), .wr_index(fill_index), .wr_tag(fill_tag),
        .wr_data(wr_inst), .wr_is_c(wr_is_c), .wr_match(fill_match[1])
    );

    // Zero-latency lookup: way0 wins a (never expected) double match; miss returns zeros.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        icache_hit       = 1'b0;
        icache_data      = 32'd0;
        icache_data_is_c = 1'b0;
        hit_way          = WAY0;
        if (icache_get_ready) begin
            if (lk_match[0]) begin
                icache_hit       = 1'b1;
                icache_data      = rd_data0;
                icache_data_is_c = rd_is_c[0];
                hit_way          = WAY0;
            end else if (lk_match[1]) begin
                icache_hit       = 1'b1;
                icache_data      = rd_data1;
                icache_data_is_c = rd_is_c[1];
                hit_way          = WAY1;
            end
        end
    end

    // Fill way choice: overwrite a resident copy in place, else replace the LRU way. Flush drops the fill.
    always_comb begin
        fill_en = rdy_in && wr_ready && !flush;
        clr_all = rdy_in && flush;
        if (fill_match[0]) begin
            fill_way = WAY0;
        end else if (fill_match[1]) begin
            fill_way = WAY1;
        end else begin
            fill_way = lru[fill_index];
        end
        way_we[0] = fill_en && (fill_way == WAY0);
        way_we[1] = fill_en && (fill_way == WAY1);
    end

    // LRU bits point at the way to replace next; a same-cycle fill overrides the lookup's update.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lru <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                lru <= '0;
            end else begin
                if (icache_hit) begin
                    lru[lk_index] <= ~hit_way;
                end
                if (fill_en) begin
                    lru[fill_index] <= ~fill_way;
                end
            end
        end
    end

`ifdef ICACHE_PERF_EN
    // Saturating lookup hit/miss counters; only reset clears them.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else if (rdy_in && icache_get_ready) begin
            if (icache_hit) begin
                if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_icache_2way.sv
// Self-checking bench for icache_2way: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a recency-list model.
module tb_icache_2way;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush = 1'b0;
    logic        icache_get_ready = 1'b0;
    logic [31:0] get_icache_addr = 32'd0;
    logic        icache_hit;
    logic [31:0] icache_data;
    logic        icache_data_is_c;
    logic        wr_ready = 1'b0;
    logic        wr_is_c = 1'b0;
    logic [31:0] wr_addr = 32'd0;
    logic [31:0] wr_inst = 32'd0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    icache_2way dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .icache_get_ready(icache_get_ready), .get_icache_addr(get_icache_addr),
        .icache_hit(icache_hit), .icache_data(icache_data), .icache_data_is_c(icache_data_is_c),
        .wr_ready(wr_ready), .wr_is_c(wr_is_c), .wr_addr(wr_addr), .wr_inst(wr_inst),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Model: per set, up to two resident entries ordered most-recent first, keyed by halfword address.
    logic [30:0] m_key  [64][2];
    logic [31:0] m_data [64][2];
    logic        m_isc  [64][2];
    int          m_cnt  [64];
    logic [31:0] m_hit = 32'd0;
    logic [31:0] m_miss = 32'd0;
    bit          m_init = 1'b0;

    logic        obs_hit, obs_isc;
    logic [31:0] obs_data, obs_hit_cnt, obs_miss_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find(input int s, input logic [30:0] k);
        for (int i = 0; i < m_cnt[s]; i++) begin
            if (m_key[s][i] == k) return i;
        end
        return -1;
    endfunction

    task automatic copy_ent(input int s, input int from, input int to);
        m_key[s][to]  = m_key[s][from];
        m_data[s][to] = m_data[s][from];
        m_isc[s][to]  = m_isc[s][from];
    endtask

    task automatic touch(input int s, input int p);
        logic [30:0] k; logic [31:0] d; logic c;
        if (p == 1) begin
            k = m_key[s][1]; d = m_data[s][1]; c = m_isc[s][1];
            copy_ent(s, 0, 1);
            m_key[s][0] = k; m_data[s][0] = d; m_isc[s][0] = c;
        end
    endtask

    // One clock: drive at negedge, compare at negedge+1, advance model at posedge.
    task automatic step(input logic rst, input logic rdy, input logic fl, input logic gr,
                        input logic [31:0] ga, input logic wr, input logic wc,
                        input logic [31:0] wa, input logic [31:0] wi);
        int li, lp, fi, fp, vp;
        logic [30:0] lk, fk, vk;
        logic ehit, eisc, evict;
        logic [31:0] edata;
        @(negedge clk_in);
        rst_in = rst; rdy_in = rdy; flush = fl; icache_get_ready = gr; get_icache_addr = ga;
        wr_ready = wr; wr_is_c = wc; wr_addr = wa; wr_inst = wi;
        #1;
        li = int'(ga[6:1]);
        lk = ga[31:1];
        lp = find(li, lk);
        ehit  = gr && (lp >= 0);
        edata = ehit ? m_data[li][lp] : 32'd0;
        eisc  = ehit ? m_isc[li][lp] : 1'b0;
        obs_hit = icache_hit; obs_data = icache_data; obs_isc = icache_data_is_c;
        obs_hit_cnt = hit_cnt; obs_miss_cnt = miss_cnt;
        if (m_init) begin
            check("hit", {31'd0, icache_hit}, {31'd0, ehit});
            check("is_c", {31'd0, icache_data_is_c}, {31'd0, eisc});
            if (ehit && eisc) check("data_c", {16'd0, icache_data[15:0]}, {16'd0, edata[15:0]});
            else              check("data", icache_data, edata);
            check("hit_cnt", hit_cnt, m_hit);
            check("miss_cnt", miss_cnt, m_miss);
        end
        @(posedge clk_in);
        if (rst) begin
            for (int s = 0; s < 64; s++) m_cnt[s] = 0;
            m_hit = 32'd0; m_miss = 32'd0; m_init = 1'b1;
        end else if (rdy) begin
`ifdef ICACHE_PERF_EN
            if (gr) begin
                if (ehit) begin if (m_hit != 32'hFFFF_FFFF) m_hit++; end
                else begin if (m_miss != 32'hFFFF_FFFF) m_miss++; end
            end
`endif
            if (fl) begin
                for (int s = 0; s < 64; s++) m_cnt[s] = 0;
            end else begin
                fi = int'(wa[6:1]);
                fk = wa[31:1];
                fp = find(fi, fk);
                // Replacement victim is the least recent entry before this edge's lookup touch.
                evict = wr && (fp < 0) && (m_cnt[fi] == 2);
                vk = evict ? m_key[fi][1] : 31'd0;
                if (ehit) touch(li, lp);
                if (wr) begin
                    fp = find(fi, fk);
                    if (fp >= 0) begin
                        m_data[fi][fp] = wi; m_isc[fi][fp] = wc;
                        touch(fi, fp);
                    end else begin
                        if (m_cnt[fi] == 1) copy_ent(fi, 0, 1);
                        else if (m_cnt[fi] == 2) begin
                            vp = find(fi, vk);
                            copy_ent(fi, 1 - vp, 1);
                        end
                        if (m_cnt[fi] < 2) m_cnt[fi]++;
                        m_key[fi][0] = fk; m_data[fi][0] = wi; m_isc[fi][0] = wc;
                    end
                end
            end
        end
    endtask

    task automatic look(input logic [31:0] a);
        step(1'b0, 1'b1, 1'b0, 1'b1, a, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] inst, input logic c);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, c, a, inst);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = (($urandom % 4) << 7) | (($urandom % 4) << 1) | ($urandom % 2);
        if ($urandom % 2 == 1) a = a | 32'h8000_0000;
        return a;
    endfunction

    initial begin
        // Reset and the first miss.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        look(32'h100);
        check("rst_hit", {31'd0, obs_hit}, 32'd0);
        check("rst_data", obs_data, 32'd0);
        check("rst_is_c", {31'd0, obs_isc}, 32'd0);
        idle();
`ifdef ICACHE_PERF_EN
        check("first_miss_cnt", obs_miss_cnt, 32'd1);
`else
        check("tied_miss_cnt", obs_miss_cnt, 32'd0);
`endif

        // 32-bit fill, lookup with bit 0 set still hits.
        fill(32'h100, 32'h00A0_0093, 1'b0);
        look(32'h100);
        check("hit_100", {31'd0, obs_hit}, 32'd1);
        check("data_100", obs_data, 32'h00A0_0093);
        check("is_c_100", {31'd0, obs_isc}, 32'd0);
        look(32'h101);
        check("hit_101", {31'd0, obs_hit}, 32'd1);

        // Compressed fill.
        fill(32'h102, 32'h0000_4501, 1'b1);
        look(32'h102);
        check("hit_102", {31'd0, obs_hit}, 32'd1);
        check("is_c_102", {31'd0, obs_isc}, 32'd1);
        check("data_102", {16'd0, obs_data[15:0]}, 32'h0000_4501);

        // Lookup strobe low never hits.
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0);
        check("no_strobe_hit", {31'd0, obs_hit}, 32'd0);

        // LRU eviction in set 0.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        fill(32'h000, 32'h1111_1111, 1'b0);
        fill(32'h080, 32'h2222_2222, 1'b0);
        look(32'h000);
        fill(32'h100, 32'h3333_3333, 1'b0);
        look(32'h080);
        check("evicted_080", {31'd0, obs_hit}, 32'd0);
        look(32'h000);
        check("kept_000", obs_data, 32'h1111_1111);
        look(32'h100);
        check("kept_100", obs_data, 32'h3333_3333);
        fill(32'h100, 32'h4444_4444, 1'b0);
        look(32'h000);
        check("inplace_keeps_000", {31'd0, obs_hit}, 32'd1);
        look(32'h100);
        check("inplace_data_100", obs_data, 32'h4444_4444);

        // Flush wins over a same-cycle fill.
        fill(32'h200, 32'h5555_5555, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h300, 32'h6666_6666);
        look(32'h200);
        check("flushed_200", {31'd0, obs_hit}, 32'd0);
        look(32'h300);
        check("dropped_300", {31'd0, obs_hit}, 32'd0);

        // rdy_in low blocks fills and counters.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 32'h400, 32'h7777_7777);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 32'h400, 32'h7777_7777);
        look(32'h400);
        check("stalled_fill_400", {31'd0, obs_hit}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            step(($urandom % 600) == 0, ($urandom % 10) != 0, ($urandom % 40) == 0,
                 ($urandom % 10) < 7, rand_addr(), ($urandom % 10) < 4, ($urandom % 2) == 1,
                 rand_addr(), $urandom);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
